// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues one word-aligned request at a time,
// and holds the returned instruction until decode consumes it.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IMemory_out,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF,
    output logic        FetchBusyF
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        VALID
    } state_t;

    state_t      state;
    logic [31:0] hold;
    logic [31:0] target;
    logic        consume;

    assign target   = {PCTargetE[31:2], 2'b00};
    assign PCPlus4F = PCF + 32'd4;

    // Consuming in VALID issues the next fetch in the same cycle.
    assign consume   = (state == VALID) && !PCSrcE && !StallF;
    assign imem_req  = (state == IDLE) || consume;
    assign imem_addr = consume ? PCPlus4F : PCF;

    assign InstrValidF = (state == VALID);
    assign FetchBusyF  = (state != VALID);
    assign IMemory_out = (state == VALID) ? hold : BUBBLE_INSTR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            PCF   <= RESET_PC;
            hold  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PCSrcE)
                        PCF <= target;
                    if (imem_gnt)
                        state <= PCSrcE ? DROP : WAIT;
                end
                WAIT: begin
                    if (PCSrcE)
                        PCF <= target;
                    if (imem_rvalid) begin
                        if (PCSrcE) begin
                            state <= IDLE;
                        end else begin
                            state <= VALID;
                            hold  <= imem_rdata;
                        end
                    end else if (PCSrcE) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (PCSrcE)
                        PCF <= target;
                    if (imem_rvalid)
                        state <= IDLE;
                end
                VALID: begin
                    if (PCSrcE) begin
                        PCF   <= target;
                        state <= IDLE;
                    end else if (!StallF) begin
                        PCF   <= PCPlus4F;
                        state <= imem_gnt ? WAIT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one word-aligned request at a time to a variable-latency instruction memory.
- Holds each returned instruction with its PC and PC+4 until the decode side accepts it.
- Handles stalls from the hazard unit and branch/jump redirects from Execute; drives a bubble while no instruction is held.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUBBLE_INSTR, 32'h0000_0000, instruction word driven when no valid instruction is held (matches the IF/ID flush value).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- StallF  input  1  hazard unit: hold the current instruction/PC
- PCSrcE  input  1  Execute: redirect to PCTargetE
- PCTargetE  input  32  redirect target; bits [1:0] ignored (treated as 0)
- imem_req  output  1  request valid to instruction memory
- imem_addr  output  32  request address (word aligned)
- imem_gnt  input  1  memory accepts request this cycle (req&&gnt = handshake)
- imem_rvalid  input  1  read data valid, exactly one per granted request
- imem_rdata  input  32  read data
- IMemory_out  output  32  held instruction, or BUBBLE_INSTR when not valid
- PCF  output  32  PC of the held/in-flight instruction
- PCPlus4F  output  32  PCF+4
- InstrValidF  output  1  IMemory_out holds a real instruction
- FetchBusyF  output  1  no valid instruction (=~InstrValidF); hazard unit flushes D on it

Behaviour:
- Reset, asynchronous, any state: PCF=RESET_PC, state IDLE, InstrValidF=0, IMemory_out=BUBBLE_INSTR, hold register cleared.
- PCPlus4F: combinational PCF+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- At most one outstanding request at any time.
- States:
- IDLE:
  - imem_req=1, imem_addr=PCF.
  - gnt && !PCSrcE -> WAIT.
  - gnt && PCSrcE -> DROP; PCF<=target.
  - !gnt && PCSrcE -> stay IDLE; PCF<=target.
- WAIT:
  - imem_req=0.
  - rvalid && !PCSrcE -> VALID; latch rdata into hold; InstrValidF<=1.
  - rvalid && PCSrcE -> IDLE; data discarded; PCF<=target.
  - !rvalid && PCSrcE -> DROP; PCF<=target.
- DROP:
  - imem_req=0; the next rvalid is discarded -> IDLE.
  - PCSrcE in DROP updates PCF (last target wins) and stays DROP until rvalid.
- VALID:
  - IMemory_out=hold.
  - PCSrcE (priority over StallF) -> IDLE; PCF<=target; InstrValidF<=0.
  - StallF: hold everything, imem_req=0.
  - Otherwise (consumed): imem_req=1, imem_addr=PCPlus4F, PCF<=PCPlus4F, InstrValidF<=0; gnt -> WAIT, !gnt -> IDLE.
- Throughput: 1 instruction per 2 cycles with a same-cycle-gnt / next-cycle-rvalid memory. First valid instruction 2 cycles after reset release under the same memory.
- rvalid in IDLE or VALID: protocol violation, ignored, no state change. This covers a response outstanding across reset.
- StallF ignored outside VALID (nothing to hold).
- IMemory_out, InstrValidF and FetchBusyF are registered/decoded from state; no combinational path from imem_rdata to outputs.

Test Plan:
- Reset release, zero-wait memory returning addr-derived data -> imem_addr sequence 0x0,0x4,0x8; InstrValidF pulses every other cycle; PCF/PCPlus4F = 0x0/0x4, 0x4/0x8.
- StallF held 3 cycles while VALID at PCF=0x8 -> IMemory_out, PCF=0x8, PCPlus4F=0xC stable; imem_req=0; next address 0xC after StallF drops.
- PCSrcE with PCTargetE=0x100 in WAIT, rvalid 2 cycles later -> DROP, stale data discarded (InstrValidF stays 0), next request imem_addr=0x100.
- PCSrcE and StallF together in VALID, target 0x203 -> redirect wins, PCF=0x200, InstrValidF=0.
- Assert rst while in WAIT, then deliver rvalid after release -> response ignored; first request is RESET_PC; IMemory_out=BUBBLE_INSTR until the real response.
- PCF=0xFFFF_FFFC consumed -> PCPlus4F=0, next imem_addr=0x0000_0000.
